// File: rtl/vc_controller.sv
// Victim cache controller: 8-entry fully-associative store between L1 and pmem.
// Swaps hits back to L1, forwards misses, writes back dirty FIFO victims.
module vc_controller #(
    parameter int width   = 128,
    parameter int entries = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l1_read,
    input  logic             l1_write,
    input  logic [15:0]      l1_address,
    input  logic             l1_dirty,
    input  logic [width-1:0] l1_wdata,
    output logic             l1_resp,
    output logic [width-1:0] l1_rdata,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [width-1:0] pmem_wdata,
    input  logic [width-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    localparam int IW = (entries > 1) ? $clog2(entries) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        MISS_FETCH,
        WB,
        INSTALL
    } state_e;

    state_e             state_q, state_d;
    logic [11:0]        tag_q  [entries];
    logic [width-1:0]   data_q [entries];
    logic [entries-1:0] valid_q, valid_d;
    logic [entries-1:0] dirty_q, dirty_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      tgt_q, tgt_d;
    logic               fifo_q, fifo_d;
    logic [11:0]        req_tag_q, req_tag_d;
    logic               resp_q, resp_d;
    logic [width-1:0]   rdata_q, rdata_d;
    logic               ins_en;
    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^l1_address[3:0];

    assign l1_resp  = resp_q;
    assign l1_rdata = rdata_q;

    // Associative tag compare of the live request against all valid entries
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < entries; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == l1_address[15:4])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Next-state, entry bookkeeping and memory-side outputs
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tgt_d        = tgt_q;
        fifo_d       = fifo_q;
        req_tag_d    = req_tag_q;
        resp_d       = 1'b0;
        rdata_d      = rdata_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        ins_en       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state_q)
            IDLE: begin
                // L1 still holds its request during the resp cycle; skip it
                if (!resp_q) begin
                    if (l1_write) begin
                        req_tag_d = l1_address[15:4];
                        if (hit) begin
                            tgt_d   = hit_idx;
                            fifo_d  = 1'b0;
                            state_d = INSTALL;
                        end else begin
                            tgt_d  = ptr_q;
                            fifo_d = 1'b1;
                            if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                                state_d = WB;
                            end else begin
                                state_d = INSTALL;
                            end
                        end
                    end else if (l1_read) begin
                        req_tag_d = l1_address[15:4];
                        tgt_d     = hit_idx;
                        state_d   = hit ? HIT : MISS_FETCH;
                    end
                end
            end
            HIT: begin
                resp_d         = 1'b1;
                rdata_d        = data_q[tgt_q];
                valid_d[tgt_q] = 1'b0;
                dirty_d[tgt_q] = 1'b0;
                state_d        = IDLE;
            end
            MISS_FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag_q, 4'b0000};
                if (pmem_resp) begin
                    resp_d  = 1'b1;
                    rdata_d = pmem_rdata;
                    state_d = IDLE;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[tgt_q], 4'b0000};
                pmem_wdata   = data_q[tgt_q];
                if (pmem_resp) begin
                    state_d = INSTALL;
                end
            end
            INSTALL: begin
                ins_en         = 1'b1;
                valid_d[tgt_q] = 1'b1;
                dirty_d[tgt_q] = l1_dirty;
                resp_d         = 1'b1;
                state_d        = IDLE;
                if (fifo_q) begin
                    ptr_d = ptr_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, per-entry flags and registered L1 response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            ptr_q     <= '0;
            tgt_q     <= '0;
            fifo_q    <= 1'b0;
            req_tag_q <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            ptr_q     <= ptr_d;
            tgt_q     <= tgt_d;
            fifo_q    <= fifo_d;
            req_tag_q <= req_tag_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Tag and line storage; contents are qualified by valid_q
    always_ff @(posedge clk) begin
        if (ins_en) begin
            tag_q[tgt_q]  <= req_tag_q;
            data_q[tgt_q] <= l1_wdata;
        end
    end

endmodule
